// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues word requests to imem and
// buffers in-order responses in a small queue that feeds decode via valid/ready.
module fetch_unit #(
  parameter int unsigned        BIN_DIG         = 32,
  parameter logic [BIN_DIG-1:0] RESET_PC        = '0,
  parameter int unsigned        DEPTH           = 4,
  parameter int unsigned        MAX_OUTSTANDING = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [BIN_DIG-1:0]         imem_req_addr,
  input  logic                       imem_resp_valid,
  input  logic [BIN_DIG-1:0]         imem_resp_data,
  input  logic                       redirect_valid,
  input  logic [BIN_DIG-1:0]         redirect_pc,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [BIN_DIG-1:0]         curr_pc_reg,
  output logic [BIN_DIG-1:0]         curr_inst,
  output logic [$clog2(DEPTH+1)-1:0] queue_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SW = CW + 1;

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e               state_q;
  logic [BIN_DIG-1:0]   fetch_pc_q;
  logic [OW-1:0]        outstanding_q;
  logic [OW-1:0]        drop_cnt_q;
  logic [PW-1:0]        head_q;
  logic [PW-1:0]        tail_q;
  logic [CW-1:0]        count_q;
  logic [TW-1:0]        trk_rd_q;
  logic [TW-1:0]        trk_wr_q;

  logic [BIN_DIG-1:0]   q_pc_q   [DEPTH];
  logic [BIN_DIG-1:0]   q_inst_q [DEPTH];
  logic [BIN_DIG-1:0]   trk_pc_q [MAX_OUTSTANDING];

  logic [SW-1:0]        credit_sum;
  logic                 req_fire;
  logic                 resp_run;
  logic                 pop;
  logic [OW-1:0]        resp_left;

  function automatic logic [TW-1:0] trk_inc(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
  endfunction

  // Credits cover both in-flight requests and occupied slots, so every
  // response is guaranteed a queue entry.
  always_comb begin
    credit_sum     = SW'(outstanding_q) + SW'(count_q);
    imem_req_valid = RST && (state_q == StRun) &&
                     (outstanding_q < OW'(MAX_OUTSTANDING)) &&
                     (credit_sum < SW'(DEPTH)) && !redirect_valid;
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    resp_run       = imem_resp_valid && (state_q == StRun) && !redirect_valid;
    dec_valid      = (count_q != '0);
    pop            = dec_valid && dec_ready && !redirect_valid;
    curr_pc_reg    = dec_valid ? q_pc_q[head_q]   : '0;
    curr_inst      = dec_valid ? q_inst_q[head_q] : '0;
    queue_count    = count_q;
    resp_left      = outstanding_q - OW'(imem_resp_valid);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= StRun;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      trk_rd_q      <= '0;
      trk_wr_q      <= '0;
    end else if (redirect_valid) begin
      // Redirect wins over any same-cycle response or pop.
      fetch_pc_q    <= {redirect_pc[BIN_DIG-1:2], 2'b00};
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      trk_rd_q      <= '0;
      trk_wr_q      <= '0;
      outstanding_q <= resp_left;
      drop_cnt_q    <= resp_left;
      state_q       <= (resp_left != '0) ? StFlush : StRun;
    end else begin
      if (req_fire) begin
        fetch_pc_q <= fetch_pc_q + BIN_DIG'(4);
        trk_wr_q   <= trk_inc(trk_wr_q);
      end
      if (state_q == StFlush) begin
        if (imem_resp_valid) begin
          outstanding_q <= outstanding_q - OW'(1);
          drop_cnt_q    <= drop_cnt_q - OW'(1);
          if (drop_cnt_q == OW'(1)) state_q <= StRun;
        end
      end else begin
        outstanding_q <= outstanding_q + OW'(req_fire) - OW'(imem_resp_valid);
        if (resp_run) begin
          tail_q   <= tail_q + PW'(1);
          trk_rd_q <= trk_inc(trk_rd_q);
        end
        if (pop) head_q <= head_q + PW'(1);
        count_q <= count_q + CW'(resp_run) - CW'(pop);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (req_fire) trk_pc_q[trk_wr_q] <= fetch_pc_q;
    if (resp_run) begin
      q_pc_q[tail_q]   <= trk_pc_q[trk_rd_q];
      q_inst_q[tail_q] <= imem_resp_data;
    end
  end

`ifndef SYNTHESIS
  always @(posedge CLK) begin
    if (RST) begin
      assert (!(resp_run && !pop && (count_q == CW'(DEPTH))))
        else $error("fetch_unit: instruction queue overflow");
      assert (!(imem_resp_valid && (outstanding_q == '0)))
        else $error("fetch_unit: response with no outstanding request");
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized + directed bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] curr_pc_reg;
  logic [31:0] curr_inst;
  logic [2:0]  queue_count;

  fetch_unit #(
    .BIN_DIG        (32),
    .RESET_PC       (32'h0),
    .DEPTH          (4),
    .MAX_OUTSTANDING(2)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .curr_pc_reg    (curr_pc_reg),
    .curr_inst      (curr_inst),
    .queue_count    (queue_count)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model state
  logic [31:0] m_fetch;
  int          m_out;
  int          m_drop;
  bit          m_flush;
  logic [31:0] m_trk[$];
  logic [31:0] mq_pc[$];
  logic [31:0] mq_inst[$];

  // Memory environment
  logic [31:0] mem_addr[$];
  int          mem_due[$];

  int lat_min = 1, lat_max = 1;
  int rdy_pct = 100, drdy_pct = 100, redir_pct = 0;

  // Bench-inserted redirects: 1 = next cycle, 2 = two outstanding and no response,
  // 3 = coincident with a response and a pop while one request is outstanding.
  int          redir_mode = 0;
  logic [31:0] redir_tgt;
  bit          redir_hit;
  int          redir_cyc;
  bit          cap_on = 0;
  logic [31:0] cap_addr[$];
  int          cap_cyc[$];
  logic [31:0] cap_dec[$];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] pick(input logic [31:0] q[$], input int idx);
    return (idx < q.size()) ? q[idx] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_fetch = 32'h0;
    m_out   = 0;
    m_drop  = 0;
    m_flush = 0;
    m_trk.delete();
    mq_pc.delete();
    mq_inst.delete();
    mem_addr.delete();
    mem_due.delete();
  endtask

  task automatic idle_inputs();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    dec_ready       = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_req_addr"},  imem_req_addr,       32'h0);
    chk({tag, "_dec_valid"}, 32'(dec_valid),      32'd0);
    chk({tag, "_curr_pc"},   curr_pc_reg,         32'h0);
    chk({tag, "_curr_inst"}, curr_inst,           32'h0);
    chk({tag, "_count"},     32'(queue_count),    32'd0);
  endtask

  // One clock cycle: entered just after a falling edge, returns at the next one.
  task automatic cycle();
    bit          e_req, e_dv;
    logic [31:0] e_pc, e_inst;
    imem_req_ready  = ($urandom_range(0, 99) < rdy_pct);
    dec_ready       = ($urandom_range(0, 99) < drdy_pct);
    imem_resp_valid = (mem_addr.size() > 0) && (mem_due[0] <= cyc);
    imem_resp_data  = imem_resp_valid ? inst_of(mem_addr[0]) : $urandom;
    redirect_valid  = 1'b0;
    redirect_pc     = $urandom;
    if (redir_pct > 0 && $urandom_range(0, 99) < redir_pct) redirect_valid = 1'b1;
    if ((redir_mode == 1) ||
        (redir_mode == 2 && m_out == 2 && !imem_resp_valid) ||
        (redir_mode == 3 && imem_resp_valid && m_out == 1 && mq_pc.size() > 0 && dec_ready)) begin
      redirect_valid = 1'b1;
      redirect_pc    = redir_tgt;
      redir_mode     = 0;
      redir_hit      = 1;
      redir_cyc      = cyc;
      cap_on         = 1;
      cap_addr.delete();
      cap_cyc.delete();
      cap_dec.delete();
    end
    #1;
    e_req  = !m_flush && m_out < 2 && (m_out + mq_pc.size()) < 4 && !redirect_valid;
    e_dv   = (mq_pc.size() != 0);
    e_pc   = e_dv ? mq_pc[0] : 32'h0;
    e_inst = e_dv ? mq_inst[0] : 32'h0;
    chk("req_valid",   32'(imem_req_valid), 32'(e_req));
    chk("req_addr",    imem_req_addr,       m_fetch);
    chk("dec_valid",   32'(dec_valid),      32'(e_dv));
    chk("curr_pc",     curr_pc_reg,         e_pc);
    chk("curr_inst",   curr_inst,           e_inst);
    chk("queue_count", 32'(queue_count),    32'(mq_pc.size()));

    if (redirect_valid) begin
      m_fetch = redirect_pc & 32'hFFFF_FFFC;
      m_trk.delete();
      mq_pc.delete();
      mq_inst.delete();
      m_out   = m_out - int'(imem_resp_valid);
      m_drop  = m_out;
      m_flush = (m_drop != 0);
    end else begin
      if (e_req && imem_req_ready) begin
        m_trk.push_back(m_fetch);
        m_fetch = m_fetch + 32'd4;
        m_out++;
      end
      if (m_flush) begin
        if (imem_resp_valid) begin
          m_out--;
          m_drop--;
          if (m_drop == 0) m_flush = 0;
        end
      end else begin
        if (e_dv && dec_ready) begin
          void'(mq_pc.pop_front());
          void'(mq_inst.pop_front());
        end
        if (imem_resp_valid && m_trk.size() > 0) begin
          mq_pc.push_back(m_trk.pop_front());
          mq_inst.push_back(imem_resp_data);
          m_out--;
        end
      end
    end

    if (cap_on && !redirect_valid) begin
      if (imem_req_valid && imem_req_ready) begin
        cap_addr.push_back(imem_req_addr);
        cap_cyc.push_back(cyc);
      end
      if (dec_valid) cap_dec.push_back(curr_pc_reg);
    end
    if (imem_resp_valid) begin
      void'(mem_addr.pop_front());
      void'(mem_due.pop_front());
    end
    if (imem_req_valid && imem_req_ready) begin
      mem_addr.push_back(imem_req_addr);
      mem_due.push_back(cyc + $urandom_range(lat_min, lat_max));
    end
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_redirect(input string tag, input int budget);
    redir_hit = 0;
    for (int i = 0; i < budget && !redir_hit; i++) cycle();
    chk({tag, "_redirect_fired"}, 32'(redir_hit), 32'd1);
  endtask

  initial begin
    idle_inputs();
    RST = 1'b0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    check_reset_outputs("reset");
    RST = 1'b1;

    // Streaming: always-ready memory, 1-cycle latency, decode always ready.
    cap_on = 1;
    run(20);
    chk("stream_addr0", pick(cap_addr, 0), 32'h0);
    chk("stream_addr2", pick(cap_addr, 2), 32'h8);
    chk("stream_dec0",  pick(cap_dec, 0),  32'h0);
    cap_on = 0;

    // Decode stalled: queue fills to DEPTH and issue stops.
    drdy_pct = 0;
    run(12);
    chk("full_count",     32'(queue_count),    32'd4);
    chk("full_req_valid", 32'(imem_req_valid), 32'd0);
    drdy_pct = 100;
    run(10);

    // Redirect with two requests in flight: both responses dropped.
    lat_min = 3; lat_max = 3;
    redir_mode = 2; redir_tgt = 32'h0000_0103;
    wait_redirect("flush", 50);
    run(12);
    chk("flush_first_req", pick(cap_addr, 0), 32'h0000_0100);
    chk("flush_first_dec", pick(cap_dec, 0),  32'h0000_0100);
    cap_on = 0;

    // Redirect coinciding with a response and a pop, one outstanding.
    lat_min = 1; lat_max = 1;
    run(6);
    redir_mode = 3; redir_tgt = 32'h0000_0202;
    wait_redirect("direct", 50);
    run(4);
    chk("direct_first_req", pick(cap_addr, 0), 32'h0000_0200);
    chk("direct_req_delay", (cap_cyc.size() > 0) ? 32'(cap_cyc[0] - redir_cyc) : 32'hFFFF_FFFF,
        32'd1);
    cap_on = 0;

    // PC wrap at the top of the address space.
    redir_mode = 1; redir_tgt = 32'hFFFF_FFF9;
    wait_redirect("wrap", 4);
    run(12);
    chk("wrap_addr0", pick(cap_addr, 0), 32'hFFFF_FFF8);
    chk("wrap_addr1", pick(cap_addr, 1), 32'hFFFF_FFFC);
    chk("wrap_addr2", pick(cap_addr, 2), 32'h0000_0000);
    cap_on = 0;

    // Randomized traffic with redirects, back-pressure and variable latency.
    lat_min = 1; lat_max = 4;
    rdy_pct = 70; drdy_pct = 60; redir_pct = 3;
    run(1500);
    redir_pct = 0;

    // Asynchronous reset between clock edges in the middle of a burst.
    lat_min = 1; lat_max = 2; rdy_pct = 100; drdy_pct = 50;
    run(8);
    idle_inputs();
    #2;
    RST = 1'b0;
    #1;
    check_reset_outputs("async");
    model_reset();
    @(posedge CLK);
    #1;
    check_reset_outputs("async_held");
    @(negedge CLK);
    RST = 1'b1;
    cap_on = 1;
    cap_addr.delete();
    cap_cyc.delete();
    cap_dec.delete();
    drdy_pct = 100;
    run(10);
    chk("async_first_req", pick(cap_addr, 0), 32'h0);
    cap_on = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
